// File: rtl/snac_md_poller_if.sv
// snac_md_poller_if: shared SNAC pad bus (select line, port split, six input pins).
// The poller is the master; the pad side (or a pad model) is the slave.
interface snac_md_poller_if;
  logic [5:0] joy_in;
  logic       joy_mdsel;
  logic       joy_split;

  modport master (
    input  joy_in,
    output joy_mdsel,
    output joy_split
  );

  modport slave (
    output joy_in,
    input  joy_mdsel,
    input  joy_split
  );
endinterface

// File: rtl/snac_md_poller.sv
// snac_md_poller: polls two DB9 / Mega Drive pads over the time-multiplexed SNAC
// port, classifies each pad and commits active-high button words per port.
// Optional feature macro: SNAC_MD6_EN enables the 8-phase sequence with
// 6-button detection and X/Y/Z/Mode decode; without it only phases 0..3 run.
//
// state  | meaning
// IDLE   | rest between frames, select high, port 1 on the mux
// POLL   | stepping select phases on the current port, sampling on phase end
// SWITCH | one step with select high and port 2 on the mux, no sampling
module snac_md_poller #(
  parameter int unsigned STEP_CYCLES = 480,
  parameter int unsigned IDLE_CYCLES = 96000
) (
  input  logic              clk,
  input  logic              reset_n,
  snac_md_poller_if.master  pad,
  output logic [11:0]       joystick1,
  output logic [11:0]       joystick2,
  output logic [1:0]        pad_type1,
  output logic [1:0]        pad_type2,
  output logic              update
);

  localparam int unsigned CNT_MAX = (IDLE_CYCLES > STEP_CYCLES) ? IDLE_CYCLES : STEP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

`ifdef SNAC_MD6_EN
  localparam logic [2:0] LAST_PH = 3'd7;
`else
  localparam logic [2:0] LAST_PH = 3'd3;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    POLL   = 2'd1,
    SWITCH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       ph_q, ph_d;
  logic             port_q, port_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             commit_q, commit_d;
  logic             commit_port_q;
  logic             tc;
  logic             sample;

  logic [5:0]       sync1_q, sync2_q;
  logic [5:0]       joy_act;

  logic cap_u, cap_d, cap_l, cap_r, cap_b, cap_c, cap_a, cap_st;
  logic md_q;
`ifdef SNAC_MD6_EN
  logic six_q;
  logic cap_x, cap_y, cap_z, cap_mode;
`endif

  logic [11:0] word;
  logic [1:0]  ptype;

  // Pins are asynchronous to clk; two flops before anything looks at them.
  // Released pins read high, so the chain resets to all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 6'h3F;
      sync2_q <= 6'h3F;
    end else begin
      sync1_q <= pad.joy_in;
      sync2_q <= sync1_q;
    end
  end

  assign joy_act = ~sync2_q;

  // Select and split are decoded straight from registered state so they only
  // move on clock edges; split changes exactly when select is (or goes) high.
  assign pad.joy_mdsel = (state_q == POLL) ? ~ph_q[0] : 1'b1;
  assign pad.joy_split = (state_q == POLL)   ? port_q :
                         (state_q == SWITCH) ? 1'b1   : 1'b0;

  assign tc     = (cnt_q == '0);
  assign sample = (state_q == POLL) && tc;

  // FSM state register: down-counter per step, phase index, current port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      ph_q          <= 3'd0;
      port_q        <= 1'b0;
      cnt_q         <= IDLE_LAST;
      commit_q      <= 1'b0;
      commit_port_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ph_q          <= ph_d;
      port_q        <= port_d;
      cnt_q         <= cnt_d;
      commit_q      <= commit_d;
      commit_port_q <= port_q;
    end
  end

  // Next-state: each step ends at terminal count; the last phase of a port
  // raises a commit request that lands one clock later.
  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    port_d   = port_q;
    cnt_d    = cnt_q - CNT_ONE;
    commit_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tc) begin
          state_d = POLL;
          ph_d    = 3'd0;
          port_d  = 1'b0;
          cnt_d   = STEP_LAST;
        end
      end
      POLL: begin
        if (tc) begin
          cnt_d = STEP_LAST;
          if (ph_q == LAST_PH) begin
            commit_d = 1'b1;
            if (!port_q) begin
              state_d = SWITCH;
            end else begin
              state_d = IDLE;
              cnt_d   = IDLE_LAST;
            end
          end else begin
            ph_d = ph_q + 3'd1;
          end
        end
      end
      SWITCH: begin
        if (tc) begin
          state_d = POLL;
          ph_d    = 3'd0;
          port_d  = 1'b1;
          cnt_d   = STEP_LAST;
        end
      end
      default: begin
        state_d = IDLE;
        ph_d    = 3'd0;
        port_d  = 1'b0;
        cnt_d   = IDLE_LAST;
      end
    endcase
  end

  // Pin capture on the last clock of each phase. md means the pad pulled
  // Left and Right low with select low, which only an MD pad does; six means
  // the third low phase pulled all four direction pins low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_u    <= 1'b0;
      cap_d    <= 1'b0;
      cap_l    <= 1'b0;
      cap_r    <= 1'b0;
      cap_b    <= 1'b0;
      cap_c    <= 1'b0;
      cap_a    <= 1'b0;
      cap_st   <= 1'b0;
      md_q     <= 1'b0;
`ifdef SNAC_MD6_EN
      six_q    <= 1'b0;
      cap_x    <= 1'b0;
      cap_y    <= 1'b0;
      cap_z    <= 1'b0;
      cap_mode <= 1'b0;
`endif
    end else if (sample) begin
      case (ph_q)
        3'd0: begin
          cap_u <= joy_act[0];
          cap_d <= joy_act[1];
          cap_l <= joy_act[2];
          cap_r <= joy_act[3];
          cap_b <= joy_act[4];
          cap_c <= joy_act[5];
        end
        3'd1: begin
          cap_a  <= joy_act[4];
          cap_st <= joy_act[5];
          md_q   <= joy_act[2] & joy_act[3];
        end
`ifdef SNAC_MD6_EN
        3'd5: begin
          six_q <= md_q & (&joy_act[3:0]);
        end
        3'd6: begin
          cap_z    <= joy_act[0];
          cap_y    <= joy_act[1];
          cap_x    <= joy_act[2];
          cap_mode <= joy_act[3];
        end
`endif
        default: ;
      endcase
    end
  end

  // Button word and class for the port being committed. A generic stick only
  // contributes its phase-0 data; a 3-button pad never reports X/Y/Z/Mode.
  always_comb begin
    word  = {4'h0, cap_st, cap_a, cap_c, cap_b, cap_u, cap_d, cap_l, cap_r};
    ptype = 2'd0;
    if (!md_q) begin
      word[11:6] = 6'h00;
      ptype      = 2'd0;
    end else begin
      ptype = 2'd1;
`ifdef SNAC_MD6_EN
      if (six_q) begin
        word[11:8] = {cap_z, cap_y, cap_x, cap_mode};
        ptype      = 2'd2;
      end
`endif
    end
  end

  // Output commit: one port's word and class update together with the pulse;
  // the other port holds.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      joystick1 <= 12'h000;
      joystick2 <= 12'h000;
      pad_type1 <= 2'd0;
      pad_type2 <= 2'd0;
      update    <= 1'b0;
    end else begin
      update <= commit_q;
      if (commit_q) begin
        if (commit_port_q) begin
          joystick2 <= word;
          pad_type2 <= ptype;
        end else begin
          joystick1 <= word;
          pad_type1 <= ptype;
        end
      end
    end
  end

endmodule

// File: tb/tb_snac_md_poller.sv
// tb_snac_md_poller: vector table of pad setups per port, a behavioural pad
// model on the SNAC bus, and a scoreboard of expected commits.
`timescale 1ns/1ps
module tb_snac_md_poller;

  localparam int STEP = 8;
  localparam int IDLE = 16;
`ifdef SNAC_MD6_EN
  localparam int NPH = 8;
`else
  localparam int NPH = 4;
`endif
  localparam int FIRST_UPD  = IDLE + NPH * STEP + 1;
  localparam int SECOND_UPD = FIRST_UPD + STEP + NPH * STEP;
  localparam int FRAME      = IDLE + (2 * NPH + 1) * STEP;

  localparam int K_GEN = 0;
  localparam int K_MD3 = 1;
  localparam int K_MD6 = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [11:0] joystick1, joystick2;
  logic [1:0]  pad_type1, pad_type2;
  logic        update;

  snac_md_poller_if pad_if ();

  snac_md_poller #(.STEP_CYCLES(STEP), .IDLE_CYCLES(IDLE)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .pad       (pad_if),
    .joystick1 (joystick1),
    .joystick2 (joystick2),
    .pad_type1 (pad_type1),
    .pad_type2 (pad_type2),
    .update    (update)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_checks = 0;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          port;
    logic [11:0] joy;
    logic [1:0]  typ;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    int          k1;
    logic [11:0] b1;
    int          k2;
    logic [11:0] b2;
    logic [11:0] e1;
    logic [1:0]  t1;
    logic [11:0] e2;
    logic [1:0]  t2;
  } vec_t;

  localparam int NV = 5;
  vec_t vecs[NV];

  int          kind1 = K_GEN, kind2 = K_GEN;
  logic [11:0] btn1 = 12'h000, btn2 = 12'h000;

  // Pad model: pins are active-low; an MD 6-button pad counts select falling
  // edges and restarts its count after select stays high for a while.
  function automatic logic [5:0] pad_pins(input int kind, input logic [11:0] b,
                                          input logic sel, input int lows);
    logic [5:0] act;
    act = {b[5], b[4], b[0], b[1], b[2], b[3]};
    if (kind != K_GEN) begin
      if (sel) begin
        if (kind == K_MD6 && lows == 3) act[3:0] = {b[8], b[9], b[10], b[11]};
      end else begin
        act[5:4] = {b[7], b[6]};
        if (kind == K_MD6 && lows == 3)      act[3:0] = 4'hF;
        else if (kind == K_MD6 && lows == 4) act[3:0] = 4'h0;
        else                                 act[3:2] = 2'b11;
      end
    end
    return ~act;
  endfunction

  int   hi_run = 100;
  int   lows = 0;
  logic prev_sel = 1'b1;

  always @(negedge clk) begin
    if (pad_if.joy_mdsel) hi_run = prev_sel ? hi_run + 1 : 1;
    else if (prev_sel)    lows = (hi_run > 12) ? 1 : lows + 1;
    prev_sel = pad_if.joy_mdsel;
    pad_if.joy_in = pad_if.joy_split ? pad_pins(kind2, btn2, pad_if.joy_mdsel, lows)
                                     : pad_pins(kind1, btn1, pad_if.joy_mdsel, lows);
  end

  int cyc = 0;
  always @(posedge clk) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  logic [11:0] hold1, hold2;
  logic [1:0]  htyp1, htyp2;
  logic        prev_split = 1'b0;
  logic        prev_upd = 1'b0;
  int          low_run = 0;

  // Monitor: bus protocol, update pulse width, scoreboard compare on update.
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      prev_split = 1'b0;
      prev_upd   = 1'b0;
      low_run    = 0;
      hold1 = 12'h000; hold2 = 12'h000;
      htyp1 = 2'd0;    htyp2 = 2'd0;
    end else begin
      if (pad_if.joy_split !== prev_split)
        check(pad_if.joy_mdsel === 1'b1, "split_while_sel_low", int'(pad_if.joy_mdsel), 1);
      prev_split = pad_if.joy_split;
      if (pad_if.joy_mdsel === 1'b0) begin
        low_run++;
      end else begin
        if (low_run != 0) check(low_run == STEP, "mdsel_low_len", low_run, STEP);
        low_run = 0;
      end
      if (prev_upd) check(update === 1'b0, "update_width", int'(update), 0);
      prev_upd = update;
      if (update === 1'b1) begin
        check(sb.size() != 0, "update_expected", sb.size(), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          if (e.cyc != 0) check(cyc == e.cyc, "update_time", cyc, e.cyc);
          if (!e.port) begin
            check(joystick1 === e.joy, "joy1", int'(joystick1), int'(e.joy));
            check(pad_type1 === e.typ, "type1", int'(pad_type1), int'(e.typ));
            check(joystick2 === hold2 && pad_type2 === htyp2, "hold2",
                  int'(joystick2), int'(hold2));
            hold1 = e.joy; htyp1 = e.typ;
          end else begin
            check(joystick2 === e.joy, "joy2", int'(joystick2), int'(e.joy));
            check(pad_type2 === e.typ, "type2", int'(pad_type2), int'(e.typ));
            check(joystick1 === hold1 && pad_type1 === htyp1, "hold1",
                  int'(joystick1), int'(hold1));
            hold2 = e.joy; htyp2 = e.typ;
          end
        end
      end
    end
  end

  task automatic push_exp(input bit port, input logic [11:0] joy, input logic [1:0] typ,
                          input int c);
    exp_t e;
    e.port = port; e.joy = joy; e.typ = typ; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic set_pads(input int i);
    kind1 = vecs[i].k1; btn1 = vecs[i].b1;
    kind2 = vecs[i].k2; btn2 = vecs[i].b2;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clk);
    sb.delete();
    @(negedge clk);
  endtask

  task automatic wait_sb(input int keep, input int budget, input string name);
    int n = 0;
    while (sb.size() > keep && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(sb.size() <= keep, name, sb.size(), keep);
  endtask

  initial begin
    //        k1     b1       k2     b2       e1       t1  e2       t2
    vecs[0] = '{K_GEN, 12'h000, K_GEN, 12'h000, 12'h000, 0, 12'h000, 0};
    vecs[1] = '{K_MD3, 12'h048, K_GEN, 12'h000, 12'h048, 1, 12'h000, 0};
`ifdef SNAC_MD6_EN
    vecs[2] = '{K_GEN, 12'h012, K_MD6, 12'h981, 12'h012, 0, 12'h981, 2};
    vecs[3] = '{K_MD6, 12'hFFF, K_MD3, 12'h0B4, 12'hFFF, 2, 12'h0B4, 1};
    vecs[4] = '{K_MD6, 12'h642, K_GEN, 12'h02D, 12'h642, 2, 12'h02D, 0};
`else
    vecs[2] = '{K_GEN, 12'h012, K_MD6, 12'h981, 12'h012, 0, 12'h081, 1};
    vecs[3] = '{K_MD6, 12'hFFF, K_MD3, 12'h0B4, 12'h0FF, 1, 12'h0B4, 1};
    vecs[4] = '{K_MD6, 12'h642, K_GEN, 12'h02D, 12'h042, 1, 12'h02D, 0};
`endif

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check(joystick1 === 12'h000, "rst_joy1", int'(joystick1), 0);
    check(joystick2 === 12'h000, "rst_joy2", int'(joystick2), 0);
    check(pad_type1 === 2'd0 && pad_type2 === 2'd0, "rst_types",
          int'({pad_type1, pad_type2}), 0);
    check(update === 1'b0, "rst_update", int'(update), 0);
    check(pad_if.joy_mdsel === 1'b1, "rst_mdsel", int'(pad_if.joy_mdsel), 1);
    check(pad_if.joy_split === 1'b0, "rst_split", int'(pad_if.joy_split), 0);

    for (int i = 0; i < NV; i++) begin
      do_reset();
      set_pads(i);
      push_exp(1'b0, vecs[i].e1, vecs[i].t1, FIRST_UPD);
      push_exp(1'b1, vecs[i].e2, vecs[i].t2, SECOND_UPD);
      reset_n = 1'b1;
      wait_sb(0, SECOND_UPD + 40, "vec_timeout");
    end

    // Steady state: the next frame repeats on the same cadence.
    push_exp(1'b0, vecs[NV-1].e1, vecs[NV-1].t1, FIRST_UPD + FRAME);
    push_exp(1'b1, vecs[NV-1].e2, vecs[NV-1].t2, SECOND_UPD + FRAME);
    wait_sb(0, FRAME + 40, "frame2_timeout");

    // Reset asserted mid-POLL of port 2, between clock edges.
    do_reset();
    set_pads(2);
    push_exp(1'b0, vecs[2].e1, vecs[2].t1, FIRST_UPD);
    reset_n = 1'b1;
    wait_sb(0, FIRST_UPD + 40, "pre_reset_timeout");
    for (int n = 0; n < 200 && cyc < FIRST_UPD + 4 * STEP; n++) @(negedge clk);
    check(cyc >= FIRST_UPD + 4 * STEP, "reach_port2_poll", cyc, FIRST_UPD + 4 * STEP);
    check(pad_if.joy_split === 1'b1, "pre_reset_split", int'(pad_if.joy_split), 1);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check(joystick1 === 12'h000, "async_rst_joy1", int'(joystick1), 0);
    check(pad_type1 === 2'd0, "async_rst_type1", int'(pad_type1), 0);
    check(pad_if.joy_mdsel === 1'b1, "async_rst_mdsel", int'(pad_if.joy_mdsel), 1);
    check(pad_if.joy_split === 1'b0, "async_rst_split", int'(pad_if.joy_split), 0);
    check(update === 1'b0, "async_rst_update", int'(update), 0);
    do_reset();
    push_exp(1'b0, vecs[2].e1, vecs[2].t1, FIRST_UPD);
    push_exp(1'b1, vecs[2].e2, vecs[2].t2, SECOND_UPD);
    reset_n = 1'b1;
    wait_sb(0, SECOND_UPD + 40, "post_reset_timeout");

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
